spi_slave_ctrl: RTL and testbench

- Parametrised SPI slave frame controller; successor to the fixed 10-bit SPI slave FSM.
- Deserialises MOSI frames of (2 command bits + PAYLOAD_W payload bits) into a parallel word for the single-port RAM.
- Serialises DATA_W-bit RAM read data back out on MISO.
- MOSI is sampled on the system clock. New behaviour: frame-abort detection, a read-address-held flag, a TX wait handshake, and mandatory SS_n deassertion between frames.

---
 rtl/spi_slave_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame controller: deserialises (2 cmd + PAYLOAD_W) bit MOSI frames
// into a parallel word and serialises DATA_W-bit read data back out on MISO.
// MOSI is sampled on the system clock; SS_n must deassert between frames.
module spi_slave_ctrl #(
    parameter int PAYLOAD_W = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [PAYLOAD_W+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic                 tx_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int F  = PAYLOAD_W + 2;
    localparam int CW = $clog2(F);
    localparam int TW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [F-2:0]      rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [F-1:0]      rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              miso_q, miso_d;
    logic              rd_addr_ok_q, rd_addr_ok_d;

    // Register all state; reset returns every output to idle values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_cnt_q     <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            rd_addr_ok_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_sh_q      <= rx_sh_d;
            tx_sh_q      <= tx_sh_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            miso_q       <= miso_d;
            rd_addr_ok_q <= rd_addr_ok_d;
        end
    end

    // Next-state and datapath: an SS_n release mid-frame always wins as an abort.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_cnt_d     = tx_cnt_q;
        rx_sh_d      = rx_sh_q;
        tx_sh_d      = tx_sh_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        miso_d       = miso_q;
        rd_addr_ok_d = rd_addr_ok_q;

        if (SS_n && state_q != IDLE && state_q != DONE) begin
            // Abort: drop the partial frame, keep rx_data and rd_addr_ok as they are.
            state_d     = IDLE;
            cnt_d       = '0;
            tx_cnt_d    = '0;
            frame_err_d = 1'b1;
            miso_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    rx_sh_d = {rx_sh_q[F-3:0], MOSI};
                    cnt_d   = CW'(1);
                    if (!MOSI)             state_d = WRITE;
                    else if (rd_addr_ok_q) state_d = READ_DATA;
                    else                   state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt_q == CW'(F - 1)) begin
                        // Whole frame lands in rx_data in one go, never partially.
                        rx_data_d  = {rx_sh_q, MOSI};
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        if (state_q == READ_DATA) begin
                            state_d = WAIT_TX;
                        end else begin
                            state_d = DONE;
                            if (state_q == READ_ADD) rd_addr_ok_d = 1'b1;
                        end
                    end else begin
                        rx_sh_d = {rx_sh_q[F-3:0], MOSI};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        // MSB goes straight to the MISO flop so it shows on the first SEND cycle.
                        tx_sh_d  = tx_data;
                        miso_d   = tx_data[DATA_W-1];
                        tx_cnt_d = '0;
                        state_d  = SEND;
                    end
                end
                SEND: begin
                    if (tx_cnt_q == TW'(DATA_W - 1)) begin
                        miso_d       = 1'b0;
                        rd_addr_ok_d = 1'b0;
                        state_d      = DONE;
                    end else begin
                        miso_d   = tx_sh_q[DATA_W-2];
                        tx_sh_d  = tx_sh_q << 1;
                        tx_cnt_d = tx_cnt_q + TW'(1);
                    end
                end
                DONE: begin
                    if (SS_n) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign MISO      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: an 8-bit and a 16-bit instance share the
// serial stimulus; each step checks only the instance it targets.
module tb_spi_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data = '0;

    logic        miso8, rxv8, busy8, ferr8;
    logic [9:0]  rx8;
    logic        miso16, rxv16, busy16, ferr16;
    logic [17:0] rx16;

    int n_cmp = 0;
    int n_bad = 0;

    spi_slave_ctrl #(.PAYLOAD_W(8), .DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso8),
        .rx_data(rx8), .rx_valid(rxv8), .tx_data(tx_data[7:0]),
        .tx_valid(tx_valid), .busy(busy8), .frame_err(ferr8)
    );

    spi_slave_ctrl #(.PAYLOAD_W(16), .DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso16),
        .rx_data(rx16), .rx_valid(rxv16), .tx_data(tx_data),
        .tx_valid(tx_valid), .busy(busy16), .frame_err(ferr16)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Select low, then n bits MSB first; returns on the cycle rx_valid should show.
    task automatic send_frame(input logic [17:0] f, input int n);
        ss_n = 1'b0;
        tick();
        for (int i = n - 1; i >= 0; i--) begin
            mosi = f[i];
            tick();
        end
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0]  exp8;
        logic [15:0] exp16;

        // Reset state
        #12;
        chk("rst_miso", miso8, 0);
        chk("rst_rx", rx8, 0);
        chk("rst_rxv", rxv8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_ferr", ferr8, 0);
        chk("rst_rdok", dut8.rd_addr_ok_q, 0);
        rst_n = 1'b1;
        tick();

        // Write frame 00_1010_0101
        ss_n = 1'b0;
        tick();
        chk("wr_busy_chk", busy8, 1);
        for (int i = 9; i >= 0; i--) begin
            exp8 = 8'hA5;
            mosi = (i > 7) ? 1'b0 : exp8[i];
            chk("wr_rxv_early", rxv8, 0);
            chk("wr_miso", miso8, 0);
            tick();
        end
        chk("wr_rx", rx8, 10'h0A5);
        chk("wr_rxv", rxv8, 1);
        tick();
        chk("wr_rxv_pulse", rxv8, 0);
        chk("wr_done_busy", busy8, 1);
        mosi = 1'b1;
        tick(); tick(); tick();
        chk("wr_done_hold", busy8, 1);
        chk("wr_done_norxv", rxv8, 0);
        chk("wr_rdok", dut8.rd_addr_ok_q, 0);
        end_frame();
        chk("wr_idle", busy8, 0);
        chk("wr_noerr", ferr8, 0);

        // Read address then read data with tx 3C
        send_frame(18'h0023C, 10);
        chk("ra_rx", rx8, 10'h23C);
        chk("ra_rxv", rxv8, 1);
        tick();
        chk("ra_rdok", dut8.rd_addr_ok_q, 1);
        end_frame();
        send_frame(18'h00300, 10);
        chk("rd_rx", rx8, 10'h300);
        chk("rd_rxv", rxv8, 1);
        tick();
        chk("rd_wait_miso", miso8, 0);
        tx_data = 16'h003C;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        exp8 = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            chk($sformatf("rd_miso_b%0d", i), miso8, exp8[i]);
            tick();
        end
        chk("rd_miso_after", miso8, 0);
        chk("rd_rdok_clr", dut8.rd_addr_ok_q, 0);
        chk("rd_done_busy", busy8, 1);
        end_frame();
        chk("rd_noerr", ferr8, 0);

        // Read-data command with rd_addr_ok=0 routes as read-address
        send_frame(18'h003AA, 10);
        chk("mis_rx", rx8, 10'h3AA);
        chk("mis_rxv", rxv8, 1);
        tx_valid = 1'b1;
        tick(); tick();
        tx_valid = 1'b0;
        chk("mis_miso", miso8, 0);
        chk("mis_rdok", dut8.rd_addr_ok_q, 1);
        end_frame();
        chk("mis_noerr", ferr8, 0);

        // Abort after 5 bits of a write frame
        ss_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            mosi = (i == 2);
            tick();
        end
        ss_n = 1'b1;
        tick();
        chk("ab5_ferr", ferr8, 1);
        chk("ab5_rxv", rxv8, 0);
        chk("ab5_busy", busy8, 0);
        chk("ab5_rx", rx8, 10'h3AA);
        chk("ab5_rdok", dut8.rd_addr_ok_q, 1);
        tick();
        chk("ab5_ferr_pulse", ferr8, 0);

        // Abort coinciding with the last bit
        ss_n = 1'b0;
        tick();
        for (int i = 9; i >= 1; i--) begin
            mosi = i[0];
            tick();
        end
        mosi = 1'b1;
        ss_n = 1'b1;
        tick();
        chk("ablast_ferr", ferr8, 1);
        chk("ablast_rxv", rxv8, 0);
        chk("ablast_rx", rx8, 10'h3AA);
        chk("ablast_busy", busy8, 0);

        // tx_valid together with SS_n high in WAIT_TX is an abort
        send_frame(18'h00301, 10);
        chk("wtx_rx", rx8, 10'h301);
        ss_n = 1'b1;
        tx_valid = 1'b1;
        tx_data = 16'h00FF;
        tick();
        tx_valid = 1'b0;
        chk("wtx_ferr", ferr8, 1);
        chk("wtx_busy", busy8, 0);
        chk("wtx_miso", miso8, 0);
        chk("wtx_rdok", dut8.rd_addr_ok_q, 1);

        // Reset in the middle of SEND
        send_frame(18'h00302, 10);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(); tick(); tick();
        chk("rs_miso_pre", miso8, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_miso", miso8, 0);
        chk("rs_busy", busy8, 0);
        chk("rs_rdok", dut8.rd_addr_ok_q, 0);
        chk("rs_rx", rx8, 0);
        #2;
        rst_n = 1'b1;
        ss_n = 1'b1;
        tick();
        send_frame(18'h00303, 10);
        chk("rs_next_rxv", rxv8, 1);
        tick();
        chk("rs_next_rdok", dut8.rd_addr_ok_q, 1);
        chk("rs_next_miso", miso8, 0);
        end_frame();
        chk("rs_next_noerr", ferr8, 0);

        // 16-bit instance: write, then read with tx A55A
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        send_frame(18'h1BEEF, 18);
        chk("w16_rx", rx16, 18'h1BEEF);
        chk("w16_rxv", rxv16, 1);
        end_frame();
        send_frame(18'h20000, 18);
        chk("ra16_rxv", rxv16, 1);
        end_frame();
        chk("ra16_rdok", dut16.rd_addr_ok_q, 1);
        send_frame(18'h30000, 18);
        chk("rd16_rx", rx16, 18'h30000);
        tick();
        tx_data = 16'hA55A;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        exp16 = 16'hA55A;
        for (int i = 15; i >= 0; i--) begin
            chk($sformatf("rd16_miso_b%0d", i), miso16, exp16[i]);
            tick();
        end
        chk("rd16_miso_after", miso16, 0);
        chk("rd16_rdok_clr", dut16.rd_addr_ok_q, 0);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
